w_loader: RTL
=============

Name: w_loader

Overview:
- Weight loader stage directly downstream of the weight address generator (ag_w).
- Consumes the generator's temp-buffer address and W_i chip-select stream, then reads the weight word from the temp buffer (1-cycle read latency).
- Writes each word into the selected W_i DPR at that bank's next free slot.
- Signals completion to the systolic array controller once the last write has retired.

Parameters:
- FEATURE_BITS, 4, feature-size exponent; matches ag_w.
- DATA_W, 8, weight word width.
- BANK_DEPTH_BITS, 5, per-DPR write-address width; depth = 2^BANK_DEPTH_BITS.

Ports:
- sys_clk  in  1  systolic array clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  level or pulse; begins a load from IDLE.
- ag_valid  in  1  ag_address/ag_cs valid this cycle.
- ag_address  in  2*FEATURE_BITS  temp-buffer address from ag_w.
- ag_cs  in  FEATURE_BITS-1  W_i bank index from ag_w.
- ag_done  in  1  ag_w finished issuing addresses.
- tb_rd_en  out  1  temp-buffer read strobe.
- tb_rd_addr  out  2*FEATURE_BITS  temp-buffer read address.
- tb_rd_data  in  DATA_W  temp-buffer data, valid the cycle after tb_rd_en.
- w_we  out  2^(FEATURE_BITS-1)  one-hot DPR write enables.
- w_addr  out  BANK_DEPTH_BITS  DPR write address.
- w_data  out  DATA_W (DATA_W+1 with W_PARITY_EN)  DPR write data.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  single-cycle completion pulse.
- overflow  out  1  sticky; a bank write was attempted past depth.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; the per-bank pointers and pipeline valid are cleared. Reset mid-load aborts immediately; no partial write completes.
- State IDLE:
  - Outputs quiescent.
  - start=1 → RUN next edge; clears all bank pointers and overflow.
  - ag_valid ignored in IDLE.
- State RUN, read stage (combinational from inputs):
  - tb_rd_en = ag_valid.
  - tb_rd_addr = ag_address.
  - ag_cs is registered alongside into stage-1 valid/cs.
- State RUN, write stage (cycle after the read):
  - If stage-1 valid: w_we = 1 << cs_q, w_addr = ptr[cs_q], w_data = tb_rd_data; then ptr[cs_q] increments.
  - Total latency from ag_valid to w_we = 1 cycle.
- Pointer full:
  - Applies when ptr[cs] = 2^BANK_DEPTH_BITS-1 and another write targets that bank.
  - That write is suppressed (w_we=0) and overflow is set sticky until the next start or reset.
  - The pointer does not wrap.
- Done handshake:
  - ag_done=1 in RUN → DRAIN.
  - If ag_valid is also 1 in that cycle, the word is accepted (read issued) before leaving RUN.
- State DRAIN: lasts one cycle, retiring any pending stage-1 write; → DONE.
- State DONE: done=1 for exactly one cycle; busy=0; → IDLE.
- start while busy: ignored. start held high in DONE re-arms one cycle later via IDLE.
- busy=1 exactly in RUN and DRAIN.

Optional Feature:
- Macro W_PARITY_EN.
- When defined: w_data is DATA_W+1 bits, with MSB = even parity (XOR reduction) of tb_rd_data; the DPR width grows accordingly.
- When undefined: w_data = tb_rd_data exactly, with no parity logic.

Decomposition:
- Package w_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - localparams N_BANKS = 2**(FEATURE_BITS-1) and ADDR_W = 2*FEATURE_BITS.
  - A function for the one-hot bank decode.
- Sub-module w_bank_ptr holds the N_BANKS pointer array.
  - Per-bank increment, full detect, and clear-on-start.
  - Instantiated once.

Test Plan:
- Reset mid-RUN: assert reset_n=0 while busy → w_we=0, busy=0, done=0 within the same cycle (async); pointers read 0 after release.
- Basic load: start; ag_valid for 4 cycles, cs=0,1,0,2, addresses 0x10..0x13, tb_rd_data=0xA0..0xA3:
  - w_we = 0x01, 0x02, 0x01, 0x04 one cycle after each read.
  - w_addr = 0, 0, 1, 0.
  - w_data = 0xA0..0xA3.
- Simultaneous ag_valid+ag_done: last word cs=3, data 0x5C is written (w_we=0x08); done pulses exactly 2 cycles after that ag_valid; busy deasserts together with the done pulse.
- Bank overflow, BANK_DEPTH_BITS=2: five writes to cs=5 → first four have w_addr 0..3; fifth has w_we=0 and overflow=1; overflow stays 1 until the next start.
- Restart and idle ignore: start during RUN → no effect. ag_valid in IDLE → tb_rd_en=0. New start after done → pointers restart at 0 and overflow cleared.
- W_PARITY_EN build: tb_rd_data=0x07 → w_data=0x107; tb_rd_data=0x03 → w_data=0x003.

Source files
------------

// File: rtl/w_pkg.sv
// w_pkg: shared sizes, FSM state type and bank decode for the weight loader.
// W_PARITY_EN widens the DPR write word by one even-parity bit.
package w_pkg;
  localparam int FEATURE_BITS = 4;
  localparam int DATA_W = 8;
  localparam int BANK_DEPTH_BITS_DEF = 5;
  localparam int N_BANKS = 2 ** (FEATURE_BITS - 1);
  localparam int ADDR_W = 2 * FEATURE_BITS;
  localparam int CS_W = FEATURE_BITS - 1;
`ifdef W_PARITY_EN
  localparam int WD_W = DATA_W + 1;
`else
  localparam int WD_W = DATA_W;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  function automatic logic [N_BANKS-1:0] bank_onehot(input logic [CS_W-1:0] cs);
    return N_BANKS'(1) << cs;
  endfunction
endpackage

// File: rtl/w_loader_if.sv
// w_loader_if: ag_w address stream, temp-buffer read port and W_i DPR write port of the weight loader.
interface w_loader_if #(parameter int BANK_DEPTH_BITS = w_pkg::BANK_DEPTH_BITS_DEF);
  import w_pkg::*;
  logic start, ag_valid, ag_done, tb_rd_en, busy, done, overflow;
  logic [ADDR_W-1:0] ag_address, tb_rd_addr;
  logic [CS_W-1:0] ag_cs;
  logic [DATA_W-1:0] tb_rd_data;
  logic [N_BANKS-1:0] w_we;
  logic [BANK_DEPTH_BITS-1:0] w_addr;
  logic [WD_W-1:0] w_data;
  modport master (
    output start, ag_valid, ag_address, ag_cs, ag_done, tb_rd_data,
    input tb_rd_en, tb_rd_addr, w_we, w_addr, w_data, busy, done, overflow
  );
  modport slave (
    input start, ag_valid, ag_address, ag_cs, ag_done, tb_rd_data,
    output tb_rd_en, tb_rd_addr, w_we, w_addr, w_data, busy, done, overflow
  );
endinterface

// File: rtl/w_bank_ptr.sv
// w_bank_ptr: per-bank next-free-slot pointers with saturating full flags and clear-on-start.
module w_bank_ptr import w_pkg::*; #(
  parameter int BANK_DEPTH_BITS = BANK_DEPTH_BITS_DEF
) (
  input  logic                       sys_clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       inc,
  input  logic [CS_W-1:0]            sel,
  output logic [BANK_DEPTH_BITS-1:0] ptr,
  output logic                       full
);
  logic [N_BANKS-1:0][BANK_DEPTH_BITS-1:0] ptr_q, ptr_d;
  logic [N_BANKS-1:0] full_q, full_d;
  // Writing the last slot marks the bank full instead of wrapping the pointer.
  always_comb begin
    ptr_d = ptr_q;
    full_d = full_q;
    if (clr) begin
      ptr_d = '0;
      full_d = '0;
    end else if (inc && !full_q[sel]) begin
      if (&ptr_q[sel]) full_d[sel] = 1'b1;
      else ptr_d[sel] = ptr_q[sel] + 1'b1;
    end
  end
  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) begin
      ptr_q <= '0;
      full_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      full_q <= full_d;
    end
  assign ptr = ptr_q[sel];
  assign full = full_q[sel];
endmodule

// File: rtl/w_loader.sv
// w_loader: reads ag_w-addressed weights from the temp buffer and writes them into per-bank W_i DPRs.
// Build with W_PARITY_EN to append an even-parity bit as the MSB of w_data.
module w_loader import w_pkg::*; #(
  parameter int BANK_DEPTH_BITS = BANK_DEPTH_BITS_DEF
) (
  input logic       sys_clk,
  input logic       reset_n,
  w_loader_if.slave bus
);
  state_e state_q, state_d;
  logic v1_q, v1_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [CS_W-1:0] cs1_q, cs1_d;
  logic [BANK_DEPTH_BITS-1:0] ptr;
  logic run, clr, full, wr, ovf_now;
  assign run = state_q == RUN;
  assign clr = state_q == IDLE && bus.start;
  assign wr = v1_q && !full;
  assign ovf_now = v1_q && full;
  w_bank_ptr #(.BANK_DEPTH_BITS(BANK_DEPTH_BITS)) u_ptr (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .clr(clr),
    .inc(v1_q),
    .sel(cs1_q),
    .ptr(ptr),
    .full(full)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = bus.start ? RUN : IDLE;
      RUN:   state_d = bus.ag_done ? DRAIN : RUN;
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
    v1_d = run && bus.ag_valid;
    cs1_d = v1_d ? bus.ag_cs : cs1_q;
    busy_d = state_d == RUN || state_d == DRAIN;
    done_d = state_d == DONE;
    ovf_d = !clr && (ovf_q || ovf_now);
  end
  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      v1_q <= 1'b0;
      cs1_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q <= v1_d;
      cs1_q <= cs1_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  assign bus.tb_rd_en = v1_d;
  assign bus.tb_rd_addr = run ? bus.ag_address : '0;
  assign bus.w_we = wr ? bank_onehot(cs1_q) : '0;
  assign bus.w_addr = wr ? ptr : '0;
`ifdef W_PARITY_EN
  assign bus.w_data = wr ? {^bus.tb_rd_data, bus.tb_rd_data} : '0;
`else
  assign bus.w_data = wr ? bus.tb_rd_data : '0;
`endif
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  // The suppressed write is flagged in its own cycle, then held sticky.
  assign bus.overflow = ovf_q || ovf_now;
endmodule
